// File: rtl/mash111_ratio_gen_if.sv
// mash111_ratio_gen_if: frequency-word load/advance controls and ratio output of the MASH 1-1-1 ratio generator
interface mash111_ratio_gen_if #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 8
);
    logic              en;
    logic              load;
    logic [INT_W-1:0]  int_in;
    logic [FRAC_W-1:0] frac_in;
    logic [INT_W:0]    div_ratio;
    logic              valid;

    modport master (output en, load, int_in, frac_in, input div_ratio, valid);
    modport slave  (input en, load, int_in, frac_in, output div_ratio, valid);
endinterface

// File: rtl/mash111_ratio_gen.sv
// mash111_ratio_gen: 3rd-order MASH 1-1-1 modulator producing N_int + y per divider cycle; MASH_DITHER_EN adds LFSR carry-in dither
module mash111_ratio_gen #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 8,
    parameter int LFSR_W = 15
) (
    input logic clk,
    input logic rst,
    mash111_ratio_gen_if.slave bus
);
    logic [FRAC_W-1:0] e1, e2, e3, frac_q;
    logic [INT_W-1:0]  int_q;
    logic              c2d1, c3d1, c3d2;
    logic              cin;
    logic [FRAC_W:0]   s1, s2, s3;
    logic signed [3:0] y;
    logic signed [INT_W+1:0] sum;
    logic [INT_W:0]    ratio_next;

    if (LFSR_W < 2) begin : g_lfsr_w_chk
        $error("LFSR_W must be at least 2");
    end

`ifdef MASH_DITHER_EN
    logic [LFSR_W-1:0] lfsr;
    assign cin = lfsr[0];
    // Fibonacci LFSR x^15+x^14+1, stepping with the modulator
    always_ff @(posedge clk) begin
        if (!rst)
            lfsr <= LFSR_W'(1);
        else if (bus.en)
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
    end
`else
    assign cin = 1'b0;
`endif

    // Chained accumulators, noise-cancelling recombination and clamp to the unsigned ratio range
    always_comb begin
        s1 = {1'b0, e1} + {1'b0, frac_q} + {{FRAC_W{1'b0}}, cin};
        s2 = {1'b0, e2} + {1'b0, s1[FRAC_W-1:0]};
        s3 = {1'b0, e3} + {1'b0, s2[FRAC_W-1:0]};
        y = 4'(s1[FRAC_W]) + 4'(s2[FRAC_W]) - 4'(c2d1) + 4'(s3[FRAC_W])
            - {2'b00, c3d1, 1'b0} + 4'(c3d2);
        sum = $signed({2'b00, int_q}) + (INT_W+2)'(y);
        ratio_next = sum[INT_W+1] ? '0 : sum[INT_W:0];
    end

    // Shadow word capture and modulator state advance; reset wins over load and en
    always_ff @(posedge clk) begin
        if (!rst) begin
            e1 <= '0;
            e2 <= '0;
            e3 <= '0;
            int_q <= '0;
            frac_q <= '0;
            c2d1 <= 1'b0;
            c3d1 <= 1'b0;
            c3d2 <= 1'b0;
            bus.div_ratio <= '0;
            bus.valid <= 1'b0;
        end else begin
            if (bus.load) begin
                int_q <= bus.int_in;
                frac_q <= bus.frac_in;
            end
            if (bus.en) begin
                e1 <= s1[FRAC_W-1:0];
                e2 <= s2[FRAC_W-1:0];
                e3 <= s3[FRAC_W-1:0];
                c2d1 <= s2[FRAC_W];
                c3d1 <= s3[FRAC_W];
                c3d2 <= c3d1;
                bus.div_ratio <= ratio_next;
            end
            bus.valid <= bus.en;
        end
    end
endmodule

// File: tb/tb_mash111_ratio_gen.sv
// tb_mash111_ratio_gen: directed checks of the MASH 1-1-1 ratio generator against hand-derived sequences
module tb_mash111_ratio_gen;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    int errs;
    longint sum;
    int mn, mx, clamps;
    int q_exp[8] = '{32, 33, 31, 34, 30, 35, 30, 33};

    mash111_ratio_gen_if #(.FRAC_W(16), .INT_W(8)) bus ();

    mash111_ratio_gen #(.FRAC_W(16), .INT_W(8), .LFSR_W(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic restart(input int ni, input int nf);
        bus.en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.int_in = 8'(ni);
        bus.frac_in = 16'(nf);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.int_in = '0;
        bus.frac_in = '0;
        tick();
        tick();
        chk("rst_ratio", int'(bus.div_ratio), 0);
        chk("rst_valid", int'(bus.valid), 0);

        restart(32, 0);
        chk("idle_valid", int'(bus.valid), 0);
        bus.en = 1'b1;
        tick();
        chk("f0_first_valid", int'(bus.valid), 1);
        chk("f0_first_ratio", int'(bus.div_ratio), 32);
        errs = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus.div_ratio != 32 || bus.valid != 1'b1) errs++;
        end
        chk("f0_run_errs", errs, 0);

        restart(32, 16'h4000);
        bus.en = 1'b1;
        sum = 0; mn = 999; mx = -1;
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (i < 8) chk("q_pattern", int'(bus.div_ratio), q_exp[i]);
            sum += bus.div_ratio;
            if (bus.div_ratio < mn) mn = bus.div_ratio;
            if (bus.div_ratio > mx) mx = bus.div_ratio;
        end
        chk("q_min_ge_29", int'(mn >= 29), 1);
        chk("q_max_le_36", int'(mx <= 36), 1);
        chk("q_sum_window", int'(sum >= 32*4096+1024-2 && sum <= 32*4096+1024+2), 1);

        restart(32, 16'h4000);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pre", int'(bus.div_ratio), q_exp[i]);
        end
        bus.en = 1'b0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.div_ratio != 31 || bus.valid != 1'b0) errs++;
        end
        chk("hold_frozen_errs", errs, 0);
        bus.en = 1'b1;
        for (int i = 3; i < 8; i++) begin
            tick();
            chk("hold_resume", int'(bus.div_ratio), q_exp[i]);
            chk("hold_resume_valid", int'(bus.valid), 1);
        end

        rst = 1'b0;
        tick();
        chk("midrst_ratio", int'(bus.div_ratio), 0);
        chk("midrst_valid", int'(bus.valid), 0);
        rst = 1'b1;
        bus.en = 1'b0;
        bus.int_in = 8'd32;
        bus.frac_in = 16'h4000;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.en = 1'b1;
        tick();
        chk("midrst_restart0", int'(bus.div_ratio), 32);
        tick();
        chk("midrst_restart1", int'(bus.div_ratio), 33);

        restart(32, 16'h4000);
        bus.en = 1'b1;
        tick();
        tick();
        chk("ld_pre", int'(bus.div_ratio), 33);
        bus.int_in = 8'd40;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk("ld_same_edge_old", int'(bus.div_ratio), 31);
        tick();
        chk("ld_next_new", int'(bus.div_ratio), 42);
        tick();
        chk("ld_next_new2", int'(bus.div_ratio), 38);

        restart(4, 16'hFFFF);
        bus.en = 1'b1;
        sum = 0; mn = 999; mx = -1; clamps = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 0) chk("ff_c0", int'(bus.div_ratio), 4);
            if (i == 1) chk("ff_c1", int'(bus.div_ratio), 7);
            if (i == 2) chk("ff_c2", int'(bus.div_ratio), 4);
            sum += bus.div_ratio;
            if (bus.div_ratio == 0) clamps++;
            if (bus.div_ratio < mn) mn = bus.div_ratio;
            if (bus.div_ratio > mx) mx = bus.div_ratio;
        end
        chk("ff_clamps", clamps, 0);
        chk("ff_min_ge_1", int'(mn >= 1), 1);
        chk("ff_max_le_8", int'(mx <= 8), 1);
        chk("ff_sum_window", int'(sum >= 4*65536+65535-2 && sum <= 4*65536+65535+2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
